cla_carry_resolve_pipe: RTL and testbench



---
 rtl/cla_pkg.sv | 17 +
 rtl/cla_group_carry.sv | 22 ++
 rtl/cla_carry_resolve_pipe.sv | 109 ++++++++++
 tb/tb_cla_carry_resolve_pipe.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// Shared sizing and the stage-1 propagate/generate register layout for the 28-bit CLA pipe.
package cla_pkg;

    localparam int CLA_WIDTH  = 28;
    localparam int CLA_GROUP  = 4;
    localparam int CLA_NGROUP = CLA_WIDTH / CLA_GROUP;

    typedef struct packed {
        logic [CLA_WIDTH-1:0]  h;
        logic [CLA_WIDTH-1:0]  p;
        logic [CLA_WIDTH-1:0]  g;
        logic [CLA_NGROUP-1:0] Pg;
        logic [CLA_NGROUP-1:0] Gg;
        logic                  cin;
    } pg_stage_t;

endpackage

// File: rtl/cla_group_carry.sv
// Ripple of carries inside one lookahead group, seeded with the group carry-in.
module cla_group_carry #(
    parameter int GROUP = 4
) (
    input  logic [GROUP-1:0] i_p,
    input  logic [GROUP-1:0] i_g,
    input  logic             i_c,
    output logic [GROUP-1:0] o_ci
);

    // o_ci[j] is the carry into bit j of the group
    always_comb begin
        logic c;
        c    = i_c;
        o_ci = '0;
        for (int unsigned j = 0; j < GROUP; j++) begin
            o_ci[j] = c;
            c       = i_g[j] | (i_p[j] & c);
        end
    end

endmodule

// File: rtl/cla_carry_resolve_pipe.sv
// Two-stage valid/ready CLA adder: stage 1 registers P/G terms, stage 2 resolves carries and registers the sum.
module cla_carry_resolve_pipe
    import cla_pkg::*;
#(
    parameter int WIDTH = CLA_WIDTH,
    parameter int GROUP = CLA_GROUP
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);

    localparam int NGROUP = WIDTH / GROUP;

    pg_stage_t        w_pg;
    pg_stage_t        r_s1;
    logic             r_s1_valid;
    logic             w_s2_ready;
    logic [NGROUP-1:0] w_gc;
    logic             w_cout;
    logic [WIDTH-1:0] w_ci;
    logic [WIDTH-1:0] w_sum;
    logic             w_ovf;

    assign w_s2_ready = !out_valid || out_ready;
    assign in_ready   = !r_s1_valid || w_s2_ready;

    always_comb begin
        logic gacc;
        gacc     = 1'b0;
        w_pg     = '0;
        w_pg.h   = in_a ^ in_b;
        w_pg.p   = in_a | in_b;
        w_pg.g   = in_a & in_b;
        w_pg.cin = in_cin;
        for (int unsigned k = 0; k < NGROUP; k++) begin
            w_pg.Pg[k] = &w_pg.p[k*GROUP +: GROUP];
            gacc = 1'b0;
            for (int unsigned j = 0; j < GROUP; j++) begin
                gacc = w_pg.g[k*GROUP+j] | (w_pg.p[k*GROUP+j] & gacc);
            end
            w_pg.Gg[k] = gacc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1       <= '0;
            r_s1_valid <= 1'b0;
        end else if (in_ready) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1 <= w_pg;
            end
        end
    end

    // Group-level lookahead chain; each group then ripples from its own carry-in
    always_comb begin
        logic c;
        c    = r_s1.cin;
        w_gc = '0;
        for (int unsigned k = 0; k < NGROUP; k++) begin
            w_gc[k] = c;
            c       = r_s1.Gg[k] | (r_s1.Pg[k] & c);
        end
        w_cout = c;
    end

    for (genvar k = 0; k < NGROUP; k++) begin : g_grp
        cla_group_carry #(
            .GROUP (GROUP)
        ) u_gc (
            .i_p  (r_s1.p[k*GROUP +: GROUP]),
            .i_g  (r_s1.g[k*GROUP +: GROUP]),
            .i_c  (w_gc[k]),
            .o_ci (w_ci[k*GROUP +: GROUP])
        );
    end

    assign w_sum = r_s1.h ^ w_ci;
    assign w_ovf = w_ci[WIDTH-1] ^ w_cout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_cout  <= 1'b0;
            out_ovf   <= 1'b0;
        end else if (w_s2_ready) begin
            out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                out_sum  <= w_sum;
                out_cout <= w_cout;
                out_ovf  <= w_ovf;
            end
        end
    end

endmodule

// File: tb/tb_cla_carry_resolve_pipe.sv
// Directed bench for cla_carry_resolve_pipe: vector table, streaming, backpressure and async reset.
module tb_cla_carry_resolve_pipe;

    localparam int W = 28;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout;
    logic         out_ovf;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    cla_carry_resolve_pipe #(
        .WIDTH (W),
        .GROUP (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic vec_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        vec_t v;
        logic [W:0] s;
        s      = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        v.a    = a;
        v.b    = b;
        v.cin  = cin;
        v.sum  = s[W-1:0];
        v.cout = s[W];
        v.ovf  = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
        return v;
    endfunction

    task automatic chk_out(input string nm, input vec_t v);
        chk({nm, ".sum"},  {4'h0, out_sum}, {4'h0, v.sum});
        chk({nm, ".cout"}, {31'h0, out_cout}, {31'h0, v.cout});
        chk({nm, ".ovf"},  {31'h0, out_ovf}, {31'h0, v.ovf});
    endtask

    task automatic run_single(input vec_t v, input int idx);
        int lat;
        @(negedge clk);
        in_a     = v.a;
        in_b     = v.b;
        in_cin   = v.cin;
        in_valid = 1'b1;
        #1;
        chk($sformatf("vec%0d.in_ready", idx), {31'h0, in_ready}, 32'h1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk($sformatf("vec%0d.latency", idx), lat, 2);
        chk_out($sformatf("vec%0d", idx), v);
    endtask

    vec_t tbl[11];
    vec_t strm[10];
    vec_t bp[3];

    initial begin
        tbl[0]  = '{a: 28'h0000003, b: 28'h0000004, cin: 1'b0, sum: 28'h0000007, cout: 1'b0, ovf: 1'b0};
        tbl[1]  = '{a: 28'hFFFFFFF, b: 28'h0000000, cin: 1'b1, sum: 28'h0000000, cout: 1'b1, ovf: 1'b0};
        tbl[2]  = '{a: 28'h7FFFFFF, b: 28'h0000001, cin: 1'b0, sum: 28'h8000000, cout: 1'b0, ovf: 1'b1};
        tbl[3]  = '{a: 28'h8000000, b: 28'h8000000, cin: 1'b0, sum: 28'h0000000, cout: 1'b1, ovf: 1'b1};
        tbl[4]  = '{a: 28'hFFFFFFF, b: 28'hFFFFFFF, cin: 1'b1, sum: 28'hFFFFFFF, cout: 1'b1, ovf: 1'b0};
        tbl[5]  = '{a: 28'h0000000, b: 28'h0000000, cin: 1'b0, sum: 28'h0000000, cout: 1'b0, ovf: 1'b0};
        tbl[6]  = '{a: 28'hAAAAAAA, b: 28'h5555555, cin: 1'b0, sum: 28'hFFFFFFF, cout: 1'b0, ovf: 1'b0};
        tbl[7]  = '{a: 28'hAAAAAAA, b: 28'h5555555, cin: 1'b1, sum: 28'h0000000, cout: 1'b1, ovf: 1'b0};
        tbl[8]  = '{a: 28'h000000F, b: 28'h0000001, cin: 1'b0, sum: 28'h0000010, cout: 1'b0, ovf: 1'b0};
        tbl[9]  = '{a: 28'h0FFFFFF, b: 28'h0000001, cin: 1'b0, sum: 28'h1000000, cout: 1'b0, ovf: 1'b0};
        tbl[10] = '{a: 28'h1234567, b: 28'h89ABCDE, cin: 1'b0, sum: 28'h9BE0245, cout: 1'b0, ovf: 1'b0};

        for (int i = 0; i < 10; i++) begin
            strm[i] = model(28'($urandom), 28'($urandom), 1'($urandom));
        end
        bp[0] = model(28'h1111111, 28'h0000001, 1'b0);
        bp[1] = model(28'h2222222, 28'h0000002, 1'b1);
        bp[2] = model(28'hF000000, 28'h1000000, 1'b0);

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_cin    = 1'b0;
        out_ready = 1'b1;
        #12;
        chk("rst.out_valid", {31'h0, out_valid}, 32'h0);
        chk("rst.out_sum", {4'h0, out_sum}, 32'h0);
        chk("rst.cout_ovf", {30'h0, out_cout, out_ovf}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst.in_ready", {31'h0, in_ready}, 32'h1);

        for (int i = 0; i < 11; i++) begin
            run_single(tbl[i], i);
        end

        // Streaming: beat t accepted at edge t shows up after edge t+1
        @(negedge clk);
        out_ready = 1'b1;
        for (int t = 0; t < 12; t++) begin
            if (t < 10) begin
                in_a     = strm[t].a;
                in_b     = strm[t].b;
                in_cin   = strm[t].cin;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (t < 10) chk($sformatf("strm%0d.in_ready", t), {31'h0, in_ready}, 32'h1);
            @(posedge clk);
            #1;
            if (t >= 1 && t <= 10) begin
                chk($sformatf("strm%0d.out_valid", t - 1), {31'h0, out_valid}, 32'h1);
                chk_out($sformatf("strm%0d", t - 1), strm[t - 1]);
            end else begin
                chk($sformatf("strm.bubble%0d", t), {31'h0, out_valid}, 32'h0);
            end
            @(negedge clk);
        end

        // Backpressure: out_ready low for 5 cycles while 3 beats are offered
        begin
            int nxt = 0;
            int oi  = 0;
            logic acc;
            logic [4:0] exp_rdy = 5'b00011;
            for (int c = 0; c < 15; c++) begin
                out_ready = (c >= 5);
                in_valid  = (nxt < 3);
                if (nxt < 3) begin
                    in_a   = bp[nxt].a;
                    in_b   = bp[nxt].b;
                    in_cin = bp[nxt].cin;
                end
                #1;
                if (c < 5) chk($sformatf("bp.in_ready.c%0d", c), {31'h0, in_ready}, {31'h0, exp_rdy[c]});
                if (c == 5) chk("bp.in_ready.release", {31'h0, in_ready}, 32'h1);
                if (c >= 2 && c <= 5) begin
                    chk($sformatf("bp.hold_valid.c%0d", c), {31'h0, out_valid}, 32'h1);
                    chk($sformatf("bp.hold_sum.c%0d", c), {4'h0, out_sum}, {4'h0, bp[0].sum});
                end
                if (out_valid && out_ready) begin
                    if (oi < 3) chk_out($sformatf("bp.out%0d", oi), bp[oi]);
                    oi++;
                end
                acc = in_valid && in_ready;
                @(posedge clk);
                if (acc) nxt++;
                @(negedge clk);
            end
            chk("bp.accepted", nxt, 3);
            chk("bp.drained", oi, 3);
            chk("bp.idle", {31'h0, out_valid}, 32'h0);
        end

        // Asynchronous reset with two beats in flight
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_a     = bp[i].a;
            in_b     = bp[i].b;
            in_cin   = bp[i].cin;
            in_valid = 1'b1;
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = 1'b0;
        #1;
        chk("ar.pre_valid", {31'h0, out_valid}, 32'h1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("ar.out_valid", {31'h0, out_valid}, 32'h0);
        chk("ar.out_sum", {4'h0, out_sum}, 32'h0);
        chk("ar.cout_ovf", {30'h0, out_cout, out_ovf}, 32'h0);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("ar.in_ready", {31'h0, in_ready}, 32'h1);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            chk($sformatf("ar.no_stale%0d", c), {31'h0, out_valid}, 32'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
